video_prefetch_buffer: RTL

// - Upstream feeder and downstream consumer for the memory manager's video port.
// - Drives videoAddress sequentially through a frame and captures one byte per videoDataReady pulse.
// - Bytes go into a small first-word-fall-through FIFO, which is drained by the pixel/palette stage via pixelRead.
// - Decouples the fixed memory-arbitration cadence (one video byte per 5-cycle round) from pixel consumption.

---
 rtl/video_prefetch_buffer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/video_prefetch_buffer.sv
// video_prefetch_buffer
//   Walks videoAddress through a frame, captures one byte per videoDataReady
//   pulse into a first-word-fall-through FIFO, and hands bytes to the pixel
//   stage through pixelRead/pixelData/pixelValid.
//   Optional feature macro: VIDEO_PREFETCH_LINE_DOUBLE_EN (fetch every line
//   twice for 2x vertical scaling).
module video_prefetch_buffer #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FRAME_WIDTH  = 320,
  parameter int unsigned FRAME_HEIGHT = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frameStart,
  output logic [16:0] videoAddress,
  input  logic [7:0]  videoData,
  input  logic        videoDataReady,
  input  logic        pixelRead,
  output logic [7:0]  pixelData,
  output logic        pixelValid,
  output logic        frameDone,
  output logic        underflow
);

  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned XW   = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned YW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [XW-1:0]   X_LAST     = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0]   Y_LAST     = YW'(FRAME_HEIGHT - 1);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] ONE_COUNT  = CNTW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t state, state_next;

  // FIFO storage and bookkeeping
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [CNTW-1:0] count;
  logic            empty, full;
  logic            push, pop;

  // Frame position tracking
  logic [XW-1:0]   col;
  logic [YW-1:0]   row;
  logic            line_end, frame_end;
  logic [16:0]     addr_next;

`ifdef VIDEO_PREFETCH_LINE_DOUBLE_EN
  logic            pass;
  logic [16:0]     line_start;
`endif

  assign empty      = (count == '0);
  assign full       = (count == FULL_COUNT);
  assign pixelValid = !empty;
  assign rd_next    = rd_ptr + PW'(1);

  // frameStart flushes everything, so it suppresses both pop and push
  assign pop  = pixelRead && !empty && !frameStart;
  assign push = (state == FETCH) && videoDataReady && !frameStart && (!full || pop);

  assign line_end = (col == X_LAST);
`ifdef VIDEO_PREFETCH_LINE_DOUBLE_EN
  assign frame_end = line_end && (row == Y_LAST) && pass;
`else
  assign frame_end = line_end && (row == Y_LAST);
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: frameStart restarts from any state; last push ends the frame
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frameStart) state_next = FETCH;
      FETCH: begin
        if (frameStart)             state_next = FETCH;
        else if (push && frame_end) state_next = DONE;
      end
      DONE:    if (frameStart) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Address to present after the current push
  always_comb begin
    addr_next = videoAddress + 17'd1;
    if (frame_end) begin
      addr_next = '0;
    end
`ifdef VIDEO_PREFETCH_LINE_DOUBLE_EN
    else if (line_end && !pass) begin
      addr_next = line_start;
    end
`endif
  end

  // Address and line counters advance only on an accepted push
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      videoAddress <= '0;
      col          <= '0;
      row          <= '0;
`ifdef VIDEO_PREFETCH_LINE_DOUBLE_EN
      pass         <= 1'b0;
      line_start   <= '0;
`endif
    end else if (frameStart) begin
      videoAddress <= '0;
      col          <= '0;
      row          <= '0;
`ifdef VIDEO_PREFETCH_LINE_DOUBLE_EN
      pass         <= 1'b0;
      line_start   <= '0;
`endif
    end else if (push) begin
      videoAddress <= addr_next;
      if (!line_end) begin
        col <= col + XW'(1);
      end else begin
        col <= '0;
`ifdef VIDEO_PREFETCH_LINE_DOUBLE_EN
        // first pass rewinds to line_start; second pass moves to the next line
        if (!pass) begin
          pass <= 1'b1;
        end else begin
          pass       <= 1'b0;
          line_start <= addr_next;
          row        <= frame_end ? '0 : row + YW'(1);
        end
`else
        row <= frame_end ? '0 : row + YW'(1);
`endif
      end
    end
  end

  // FIFO storage write port (no reset needed on data)
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= videoData;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (frameStart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // FWFT head register: holds the last byte once the FIFO drains.
  // With more than one entry the next head is already in mem; otherwise a
  // push into an empty (or emptying) FIFO bypasses straight to the head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixelData <= '0;
    end else if (!frameStart) begin
      if (pop && (count > ONE_COUNT)) pixelData <= mem[rd_next];
      else if (push && (empty || pop)) pixelData <= videoData;
    end
  end

  // One-cycle pulse following the push of the frame's last byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) frameDone <= 1'b0;
    else       frameDone <= push && frame_end;
  end

  // Sticky flag for reads attempted on an empty FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    underflow <= 1'b0;
    else if (frameStart)          underflow <= 1'b0;
    else if (pixelRead && empty)  underflow <= 1'b1;
  end

endmodule
